// File: rtl/instr_decode_stage_if.sv
// Fetch-side and decode-side handshake bundle for instr_decode_stage.
// The master modport is the environment view; slave is the decode stage.
interface instr_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [5:0]      out_opcode;
    logic [4:0]      out_rs;
    logic [4:0]      out_rt;
    logic [4:0]      out_rd;
    logic [4:0]      out_shamt;
    logic [5:0]      out_funct;
    logic [1:0]      out_type;
    logic [XLEN-1:0] out_imm_ext;
    logic [XLEN-1:0] out_jaddr;
    logic [XLEN-1:0] out_pc;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd,
               out_shamt, out_funct, out_type, out_imm_ext, out_jaddr, out_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd,
               out_shamt, out_funct, out_type, out_imm_ext, out_jaddr, out_pc
    );
endinterface

// File: rtl/instr_decode_stage.sv
// Registered MIPS decode stage: decodes on the input side and buffers two fully
// decoded records behind a valid/ready handshake, with flush and a consumed-entry counter.
module instr_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    output logic [CNT_W-1:0] decode_count,
    instr_decode_stage_if.slave bus
);

    typedef struct packed {
        logic [5:0]      opcode;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      shamt;
        logic [5:0]      funct;
        logic [1:0]      itype;
        logic [XLEN-1:0] imm_ext;
        logic [XLEN-1:0] jaddr;
        logic [XLEN-1:0] pc;
    } rec_t;

    // Logical immediates zero-extend; lui places the sign-extended value in the upper half.
    function automatic logic [XLEN-1:0] imm_extend(input logic [5:0] opcode, input logic [15:0] imm);
        logic [XLEN-1:0] sext;
        sext = {{(XLEN-16){imm[15]}}, imm};
        case (opcode)
            6'h0C, 6'h0D, 6'h0E: imm_extend = {{(XLEN-16){1'b0}}, imm};
            6'h0F:               imm_extend = sext << 16;
            default:             imm_extend = sext;
        endcase
    endfunction

    rec_t       mem_r [2];
    rec_t       rec_s;
    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic [1:0] occ_r;
    logic [1:0] occ_next_s;
    logic       in_ready_r;
    logic       out_valid_r;
    logic [CNT_W-1:0] decode_count_r;
    logic       push_s;
    logic       pop_s;

    assign push_s = bus.in_valid & in_ready_r & ~flush;
    assign pop_s  = out_valid_r & bus.out_ready;

    // Decode the incoming word into a complete record before it is stored.
    always_comb begin
        rec_s         = '0;
        rec_s.opcode  = bus.in_instr[31:26];
        rec_s.rs      = bus.in_instr[25:21];
        rec_s.rt      = bus.in_instr[20:16];
        rec_s.rd      = bus.in_instr[15:11];
        rec_s.shamt   = bus.in_instr[10:6];
        rec_s.funct   = bus.in_instr[5:0];
        rec_s.imm_ext = imm_extend(bus.in_instr[31:26], bus.in_instr[15:0]);
        // Upper bits of pc+4 merged with the word-aligned 26-bit target.
        rec_s.jaddr   = ((bus.in_pc + XLEN'(32'd4)) & ~XLEN'(32'h0FFF_FFFF))
                      | XLEN'({bus.in_instr[25:0], 2'b00});
        rec_s.pc      = bus.in_pc;
        case (bus.in_instr[31:26])
            6'h00:        rec_s.itype = 2'b00;
            6'h02, 6'h03: rec_s.itype = 2'b10;
            default:      rec_s.itype = 2'b01;
        endcase
    end

    // Next occupancy from the push/pop pair.
    always_comb begin
        occ_next_s = occ_r;
        case ({push_s, pop_s})
            2'b10:   occ_next_s = occ_r + 2'd1;
            2'b01:   occ_next_s = occ_r - 2'd1;
            default: occ_next_s = occ_r;
        endcase
    end

    // FIFO storage, pointers and the registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0]    <= '0;
            mem_r[1]    <= '0;
            wr_ptr_r    <= 1'b0;
            rd_ptr_r    <= 1'b0;
            occ_r       <= 2'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r    <= 1'b0;
            rd_ptr_r    <= 1'b0;
            occ_r       <= 2'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= rec_s;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            occ_r       <= occ_next_s;
            in_ready_r  <= (occ_next_s < 2'd2);
            out_valid_r <= (occ_next_s != 2'd0);
        end
    end

    // Consumed-entry counter; a pop in a flush cycle still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decode_count_r <= '0;
        end else if (pop_s) begin
            decode_count_r <= decode_count_r + CNT_W'(1);
        end else begin
            decode_count_r <= decode_count_r;
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_opcode  = mem_r[rd_ptr_r].opcode;
    assign bus.out_rs      = mem_r[rd_ptr_r].rs;
    assign bus.out_rt      = mem_r[rd_ptr_r].rt;
    assign bus.out_rd      = mem_r[rd_ptr_r].rd;
    assign bus.out_shamt   = mem_r[rd_ptr_r].shamt;
    assign bus.out_funct   = mem_r[rd_ptr_r].funct;
    assign bus.out_type    = mem_r[rd_ptr_r].itype;
    assign bus.out_imm_ext = mem_r[rd_ptr_r].imm_ext;
    assign bus.out_jaddr   = mem_r[rd_ptr_r].jaddr;
    assign bus.out_pc      = mem_r[rd_ptr_r].pc;
    assign decode_count    = decode_count_r;

endmodule
